// File: rtl/rv_rf_wport_arb.sv
// Register-file write-port owner: post-reset clear of x1..x31, then arbitration of ALU/CSR (req0)
// and load (req1) writebacks onto one registered write port. RV_RF_ARB_FIXED_PRIO_EN selects fixed req1 priority.
`ifndef XLEN
`define XLEN 32
`endif

module rv_rf_wport_arb #(
    parameter int unsigned DW     = `XLEN,
    parameter bit          CLR_EN = 1'b1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             i_arb_clk,
    input  logic             i_arb_rstn,
    input  logic             i_arb_req0_valid,
    input  logic [4:0]       i_arb_req0_wa,
    input  logic [DW-1:0]    i_arb_req0_wd,
    output logic             o_arb_req0_ready,
    input  logic             i_arb_req1_valid,
    input  logic [4:0]       i_arb_req1_wa,
    input  logic [DW-1:0]    i_arb_req1_wd,
    output logic             o_arb_req1_ready,
    output logic             o_arb_rf_we,
    output logic [4:0]       o_arb_rf_wa,
    output logic [DW-1:0]    o_arb_rf_wd,
    output logic             o_arb_busy,
    output logic [CNT_W-1:0] o_arb_conflict_cnt
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam state_t RST_STATE = CLR_EN ? ST_CLEAR : ST_RUN;

    state_t           state, state_nxt;
    logic [4:0]       clr_cnt, clr_cnt_nxt;
    logic             run;
    logic             grant0, grant1;
    logic             we_q, we_nxt;
    logic [4:0]       wa_q, wa_nxt;
    logic [DW-1:0]    wd_q, wd_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    assign run = (state == ST_RUN);

`ifdef RV_RF_ARB_FIXED_PRIO_EN
    always_comb begin
        grant1 = run & i_arb_req1_valid;
        grant0 = run & i_arb_req0_valid & ~i_arb_req1_valid;
    end
`else
    // rr_ptr=0 prefers req0; flips to the other requester after every grant
    logic rr_ptr, rr_ptr_nxt;

    always_comb begin
        grant0     = run & i_arb_req0_valid & (~i_arb_req1_valid | ~rr_ptr);
        grant1     = run & i_arb_req1_valid & (~i_arb_req0_valid | rr_ptr);
        rr_ptr_nxt = rr_ptr;
        if (grant0) begin
            rr_ptr_nxt = 1'b1;
        end else if (grant1) begin
            rr_ptr_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_arb_clk or negedge i_arb_rstn) begin
        if (!i_arb_rstn) begin
            rr_ptr <= 1'b0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        we_nxt      = 1'b0;
        wa_nxt      = wa_q;
        wd_nxt      = wd_q;
        cnt_nxt     = cnt_q;
        case (state)
            ST_CLEAR: begin
                we_nxt      = 1'b1;
                wa_nxt      = clr_cnt;
                wd_nxt      = '0;
                clr_cnt_nxt = clr_cnt + 5'd1;
                if (clr_cnt == 5'd31) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // x0 writes still handshake but never assert the regfile enable
                if (grant0) begin
                    we_nxt = (i_arb_req0_wa != 5'd0);
                    wa_nxt = i_arb_req0_wa;
                    wd_nxt = i_arb_req0_wd;
                end else if (grant1) begin
                    we_nxt = (i_arb_req1_wa != 5'd0);
                    wa_nxt = i_arb_req1_wa;
                    wd_nxt = i_arb_req1_wd;
                end
                if (i_arb_req0_valid && i_arb_req1_valid && (cnt_q != '1)) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge i_arb_clk or negedge i_arb_rstn) begin
        if (!i_arb_rstn) begin
            state   <= RST_STATE;
            clr_cnt <= 5'd1;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            we_q    <= we_nxt;
            wa_q    <= wa_nxt;
            wd_q    <= wd_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign o_arb_req0_ready   = grant0;
    assign o_arb_req1_ready   = grant1;
    assign o_arb_rf_we        = we_q;
    assign o_arb_rf_wa        = wa_q;
    assign o_arb_rf_wd        = wd_q;
    assign o_arb_busy         = (state == ST_CLEAR);
    assign o_arb_conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rv_rf_wport_arb.sv
// Self-checking bench for rv_rf_wport_arb: directed phases with random requester traffic,
// checked every cycle against a behavioural model of the clear sequence and arbitration rules.
`timescale 1ns/1ps

module tb_rv_rf_wport_arb;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          v0, v1;
    logic [4:0]    wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic          rdy0, rdy1;
    logic          rf_we;
    logic [4:0]    rf_wa;
    logic [DW-1:0] rf_wd;
    logic          busy;
    logic [7:0]    ccnt;

    rv_rf_wport_arb #(.DW(DW), .CLR_EN(1'b1), .CNT_W(8)) dut (
        .i_arb_clk          (clk),
        .i_arb_rstn         (rst_n),
        .i_arb_req0_valid   (v0),
        .i_arb_req0_wa      (wa0),
        .i_arb_req0_wd      (wd0),
        .o_arb_req0_ready   (rdy0),
        .i_arb_req1_valid   (v1),
        .i_arb_req1_wa      (wa1),
        .i_arb_req1_wd      (wd1),
        .o_arb_req1_ready   (rdy1),
        .o_arb_rf_we        (rf_we),
        .o_arb_rf_wa        (rf_wa),
        .o_arb_rf_wd        (rf_wd),
        .o_arb_busy         (busy),
        .o_arb_conflict_cnt (ccnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: next clear address (32 = clear finished), preference, counter, expected outputs
    int            m_clr;
    bit            m_pref1;
    int            m_cnt;
    bit            e_we;
    logic [4:0]    e_wa;
    logic [DW-1:0] e_wd;

    // stimulus mode per requester: 0 random, 1 always valid, 2 idle, 3 always valid same wa
    int mode0, mode1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_clr   = 1;
        m_pref1 = 1'b0;
        m_cnt   = 0;
        e_we    = 1'b0;
        e_wa    = '0;
        e_wd    = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"},   64'(rf_we), 64'(0));
        chk({tag, "_wa"},   64'(rf_wa), 64'(0));
        chk({tag, "_wd"},   64'(rf_wd), 64'(0));
        chk({tag, "_rdy0"}, 64'(rdy0),  64'(0));
        chk({tag, "_rdy1"}, 64'(rdy1),  64'(0));
        chk({tag, "_busy"}, 64'(busy),  64'(1));
        chk({tag, "_cnt"},  64'(ccnt),  64'(0));
    endtask

    task automatic refill(input bit g0, input bit g1);
        if (g0 || !v0) begin
            case (mode0)
                0:       v0 = 1'($urandom_range(0, 1));
                1, 3:    v0 = 1'b1;
                default: v0 = 1'b0;
            endcase
            if (mode0 != 3) wa0 = 5'($urandom_range(0, 31));
            wd0 = $urandom;
        end
        if (g1 || !v1) begin
            case (mode1)
                0:       v1 = 1'($urandom_range(0, 1));
                1, 3:    v1 = 1'b1;
                default: v1 = 1'b0;
            endcase
            if (mode1 != 3) wa1 = 5'($urandom_range(0, 31));
            wd1 = $urandom;
        end
    endtask

    // entered at posedge+1, samples at posedge+4, returns at next posedge+1
    task automatic cyc();
        bit mbusy, g0, g1;
        #3;
        mbusy = (m_clr <= 31);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!mbusy) begin
            if (v0 && v1) begin
`ifdef RV_RF_ARB_FIXED_PRIO_EN
                g1 = 1'b1;
`else
                if (m_pref1) g1 = 1'b1;
                else         g0 = 1'b1;
`endif
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        chk("busy", 64'(busy), 64'(mbusy));
        chk("rdy0", 64'(rdy0), 64'(g0));
        chk("rdy1", 64'(rdy1), 64'(g1));
        chk("cnt",  64'(ccnt), 64'(m_cnt));
        chk("we",   64'(rf_we), 64'(e_we));
        if (e_we) begin
            chk("wa", 64'(rf_wa), 64'(e_wa));
            chk("wd", 64'(rf_wd), 64'(e_wd));
        end
        if (mbusy) begin
            e_we = 1'b1;
            e_wa = 5'(m_clr);
            e_wd = '0;
            m_clr++;
        end else if (g0) begin
            e_we = (wa0 != 0);
            e_wa = wa0;
            e_wd = wd0;
        end else if (g1) begin
            e_we = (wa1 != 0);
            e_wa = wa1;
            e_wd = wd1;
        end else begin
            e_we = 1'b0;
        end
        if (g0) m_pref1 = 1'b1;
        if (g1) m_pref1 = 1'b0;
        if (!mbusy && v0 && v1 && m_cnt < 255) m_cnt++;
        @(posedge clk);
        #1;
        refill(g0, g1);
    endtask

    task automatic drain();
        mode0 = 2;
        mode1 = 2;
        for (int k = 0; k < 8 && (v0 || v1); k++) cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        v0 = 1'b1; wa0 = 5'd4; wd0 = 32'h1111_1111;
        v1 = 1'b1; wa1 = 5'd6; wd1 = 32'h2222_2222;
        mode0 = 1; mode1 = 1;
        reset_model();
        #3;
        chk_reset("rst");

        // clear sequence with both requesters pending; they must be ignored
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (36) cyc();

        // single req0 write, then idle
        drain();
        v0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
        cyc();
        chk("c_we1", 64'(rf_we), 64'(1));
        chk("c_wd1", 64'(rf_wd), 64'hDEAD_BEEF);
        cyc();
        cyc();

        // reset while a write is in the output stage
        v1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0BAD_F00D;
        cyc();
        chk("c_we2", 64'(rf_we), 64'(1));
        #2 rst_n = 1'b0;
        #1 reset_model();
        chk_reset("mid_run");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (33) cyc();

        // four contending cycles, re-presenting the same destinations
        mode0 = 3; mode1 = 3;
        v0 = 1'b1; wa0 = 5'd3; wd0 = $urandom;
        v1 = 1'b1; wa1 = 5'd7; wd1 = $urandom;
        repeat (4) cyc();
        chk("conf4", 64'(ccnt), 64'(4));
        drain();

        // load write to x0 is accepted but dropped
        v1 = 1'b1; wa1 = 5'd0; wd1 = 32'h0000_1234;
        cyc();
        chk("x0_we", 64'(rf_we), 64'(0));
        cyc();

        // reset mid-clear, restart from x1
        rst_n = 1'b0;
        #1 reset_model();
        chk_reset("pre_clr");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) cyc();
        chk("clr_wa12", 64'(rf_wa), 64'(12));
        #2 rst_n = 1'b0;
        #1 reset_model();
        chk_reset("mid_clr");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (33) cyc();

        // conflict counter saturation
        mode0 = 3; mode1 = 3;
        v0 = 1'b1; wa0 = 5'd3; wd0 = $urandom;
        v1 = 1'b1; wa1 = 5'd7; wd1 = $urandom;
        repeat (4) cyc();
        mode0 = 1; mode1 = 1;
        repeat (300) cyc();
        chk("sat", 64'(ccnt), 64'(255));
        drain();

        // random traffic
        mode0 = 0; mode1 = 0;
        repeat (400) cyc();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
